// File: rtl/midi_multi_divider_if.sv
// Divisor write bus for midi_multi_divider: one strobed write per cycle,
// no backpressure. Optional macro PHASE_RESTART_EN adds Wr_restart.
interface midi_multi_divider_if #(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned DIV_W  = 24
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              Wr_en;
   logic [CH_W-1:0]   Wr_ch;
   logic [DIV_W-1:0]  Wr_div;
`ifdef PHASE_RESTART_EN
   logic              Wr_restart;

   modport master (output Wr_en, output Wr_ch, output Wr_div, output Wr_restart);
   modport slave  (input  Wr_en, input  Wr_ch, input  Wr_div, input  Wr_restart);
`else
   modport master (output Wr_en, output Wr_ch, output Wr_div);
   modport slave  (input  Wr_en, input  Wr_ch, input  Wr_div);
`endif
endinterface

// File: rtl/midi_multi_divider.sv
// midi_multi_divider: NUM_CH independent clock dividers, each producing a
// 50 % square wave and a one-cycle tick every active_div clocks. New
// divisors are shadowed and applied only at the channel's period boundary
// (or immediately while the channel is muted), so outputs never glitch.
// Optional macro PHASE_RESTART_EN: a write with Wr_restart=1 applies the
// divisor on the next edge and restarts the channel phase (note retrigger).
module midi_multi_divider #(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned DIV_W  = 24
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 En,
   midi_multi_divider_if.slave  wr,
   output logic [NUM_CH-1:0]    Sq_out,
   output logic [NUM_CH-1:0]    Tick,
   output logic [NUM_CH-1:0]    Pending
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [DIV_W-1:0]  active_div_q [NUM_CH];
   logic [DIV_W-1:0]  active_div_d [NUM_CH];
   logic [DIV_W-1:0]  pend_div_q   [NUM_CH];
   logic [DIV_W-1:0]  pend_div_d   [NUM_CH];
   logic [DIV_W-1:0]  cnt_q        [NUM_CH];
   logic [DIV_W-1:0]  cnt_d        [NUM_CH];
   logic [NUM_CH-1:0] pend_valid_q, pend_valid_d;
   logic [NUM_CH-1:0] sq_q, sq_d;
   logic [NUM_CH-1:0] tick_q, tick_d;

   logic [NUM_CH-1:0] wr_sel;
   logic [NUM_CH-1:0] muted;
   logic [NUM_CH-1:0] term;

   // Decode the write port; out-of-range channel indices select nothing.
   always_comb begin
      wr_sel = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         wr_sel[i] = wr.Wr_en && (wr.Wr_ch == CH_W'(i));
      end
   end

   // Per-channel status: muted (divisor 0) and terminal count reached.
   always_comb begin
      muted = '0;
      term  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         muted[i] = (active_div_q[i] == '0);
         term[i]  = (cnt_q[i] == (active_div_q[i] - DIV_W'(1)));
      end
   end

   // Next-state: counting, boundary application of shadow divisors, writes.
   always_comb begin
      active_div_d = active_div_q;
      pend_div_d   = pend_div_q;
      cnt_d        = cnt_q;
      pend_valid_d = pend_valid_q;
      sq_d         = sq_q;
      tick_d       = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (En) begin
            if (muted[i]) begin
               cnt_d[i] = '0;
               sq_d[i]  = 1'b0;
               if (pend_valid_q[i]) begin
                  active_div_d[i] = pend_div_q[i];
                  pend_valid_d[i] = 1'b0;
               end
            end else if (term[i]) begin
               cnt_d[i]  = '0;
               tick_d[i] = 1'b1;
               if (pend_valid_q[i]) begin
                  active_div_d[i] = pend_div_q[i];
                  pend_valid_d[i] = 1'b0;
                  // Applying a zero divisor mutes the channel low, not toggled.
                  sq_d[i] = (pend_div_q[i] == '0) ? 1'b0 : ~sq_q[i];
               end else begin
                  sq_d[i] = ~sq_q[i];
               end
            end else begin
               cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
         end
         // A write in a boundary cycle lands after the boundary consumed the
         // previous shadow value, so it waits for the following boundary.
         if (wr_sel[i]) begin
            pend_div_d[i]   = wr.Wr_div;
            pend_valid_d[i] = 1'b1;
         end
`ifdef PHASE_RESTART_EN
         if (wr_sel[i] && wr.Wr_restart) begin
            active_div_d[i] = wr.Wr_div;
            cnt_d[i]        = '0;
            sq_d[i]         = 1'b0;
            tick_d[i]       = 1'b0;
            pend_valid_d[i] = 1'b0;
         end
`endif
      end
   end

   // State registers with asynchronous active-low reset; every channel muted.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            active_div_q[i] <= '0;
            pend_div_q[i]   <= '0;
            cnt_q[i]        <= '0;
         end
         pend_valid_q <= '0;
         sq_q         <= '0;
         tick_q       <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            active_div_q[i] <= active_div_d[i];
            pend_div_q[i]   <= pend_div_d[i];
            cnt_q[i]        <= cnt_d[i];
         end
         pend_valid_q <= pend_valid_d;
         sq_q         <= sq_d;
         tick_q       <= tick_d;
      end
   end

   assign Sq_out  = sq_q;
   assign Tick    = tick_q;
   assign Pending = pend_valid_q;

endmodule
